// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Multi-cycle little-endian data memory with valid/ready requests
//            and a one-cycle response carrying load data and an error flag.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RspValid,
  output logic [31:0] RspRData,
  output logic        RspError
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [CW-1:0] c_LOAD = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_write;
  logic [1:0]    r_size;
  logic          r_signed;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_direct;
  logic          w_commit;
  logic          w_write;
  logic [1:0]    w_size;
  logic          w_signed;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic          w_err;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;
  logic [31:0]   w_load;

  assign ReqReady = (r_state == c_IDLE);
  assign RspValid = (r_state == c_RESP);
  assign RspRData = r_rdata;
  assign RspError = r_err;

  // With zero latency the commit happens on the acceptance edge, so the
  // access is decoded straight from the request ports while idle.
  assign w_direct = (r_state == c_IDLE);
  assign w_write  = w_direct ? ReqWrite  : r_write;
  assign w_size   = w_direct ? ReqSize   : r_size;
  assign w_signed = w_direct ? ReqSigned : r_signed;
  assign w_addr   = w_direct ? ReqAddr   : r_addr;
  assign w_wdata  = w_direct ? ReqWData  : r_wdata;
  assign w_commit = (LATENCY == 0) ? (w_direct && ReqValid)
                                   : ((r_state == c_WAIT) && (r_cnt == '0));

  assign w_idx  = w_addr[AW+1:2];
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
  assign w_half = w_word[{w_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_be   = '0;
    w_wd   = '0;
    w_load = '0;
    w_err  = (w_size == 2'b11)
          || ((w_size == 2'b01) && w_addr[0])
          || ((w_size == 2'b10) && (w_addr[1:0] != 2'b00))
          || ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
    case (w_size)
      2'b00: begin
        w_be   = 4'b0001 << w_addr[1:0];
        w_wd   = {4{w_wdata[7:0]}};
        w_load = {{24{w_signed & w_byte[7]}}, w_byte};
      end
      2'b01: begin
        w_be   = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wd   = {2{w_wdata[15:0]}};
        w_load = {{16{w_signed & w_half[15]}}, w_half};
      end
      2'b10: begin
        w_be   = 4'b1111;
        w_wd   = w_wdata;
        w_load = w_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state  <= c_IDLE;
      r_cnt    <= '0;
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (ReqValid) begin
            r_write  <= ReqWrite;
            r_size   <= ReqSize;
            r_signed <= ReqSigned;
            r_addr   <= ReqAddr;
            r_wdata  <= ReqWData;
            if (LATENCY == 0) begin
              r_state <= c_RESP;
            end else begin
              r_state <= c_WAIT;
              r_cnt   <= c_LOAD;
            end
          end
        end
        c_WAIT: begin
          if (r_cnt == '0) r_state <= c_RESP;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        c_RESP:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_write) ? '0 : w_load;
      end
    end
  end

  // Reset is tested here so a reset coinciding with the commit edge drops the write.
  always_ff @(posedge Clk) begin
    if (Reset && w_commit && w_write && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Randomized self-checking bench against a word-array memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic v2, rdy2, wr2, sg2, rv2, re2;
  logic [1:0]  sz2;
  logic [31:0] a2, wd2, rd2;
  logic v0, rdy0, wr0, sg0, rv0, re0;
  logic [1:0]  sz0;
  logic [31:0] a0, wd0, rd0;

  int n_vec = 0;
  int n_miscompare = 0;
  logic [31:0] mdl [16];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut2 (
    .Clk(clk), .Reset(rst_n), .ReqValid(v2), .ReqReady(rdy2), .ReqWrite(wr2),
    .ReqSize(sz2), .ReqSigned(sg2), .ReqAddr(a2), .ReqWData(wd2),
    .RspValid(rv2), .RspRData(rd2), .RspError(re2));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
    .Clk(clk), .Reset(rst_n), .ReqValid(v0), .ReqReady(rdy0), .ReqWrite(wr0),
    .ReqSize(sz0), .ReqSigned(sg0), .ReqAddr(a0), .ReqWData(wd0),
    .RspValid(rv0), .RspRData(rd0), .RspError(re0));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: memory as an array of words, lanes selected with shifts and masks.
  function automatic void model(input bit wr, input logic [1:0] sz, input bit sg,
                                input logic [31:0] a, input logic [31:0] wd,
                                output bit err, output logic [31:0] rd);
    int lane;
    logic [31:0] w, m, v;
    err = (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0) || (a / 4 >= DEPTH);
    rd = 0;
    if (err) return;
    lane = int'(a % 4);
    w = mdl[a / 4];
    if (sz == 2)      m = 32'hFFFF_FFFF;
    else if (sz == 1) m = 32'h0000_FFFF << (8 * lane);
    else              m = 32'h0000_00FF << (8 * lane);
    if (wr) begin
      mdl[a / 4] = (w & ~m) | ((wd << (8 * lane)) & m);
    end else begin
      v = (w & m) >> (8 * lane);
      if (sg && sz == 0 && v[7])  v = v | 32'hFFFF_FF00;
      if (sg && sz == 1 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endfunction

  task automatic req2(input bit wr, input logic [1:0] sz, input bit sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output bit err);
    int n;
    @(negedge clk);
    check_eq("ready_idle", 32'(rdy2), 1);
    wr2 = wr; sz2 = sz; sg2 = sg; a2 = a; wd2 = wd; v2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v2 = 1'b0;
    n = 0;
    while (!rv2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("latency", n, 2);
    check_eq("ready_in_resp", 32'(rdy2), 0);
    rd  = rd2;
    err = re2;
    @(negedge clk);
    check_eq("ready_back", 32'(rdy2), 1);
    check_eq("rsp_pulse", 32'(rv2), 0);
    check_eq("rdata_hold", rd2, rd);
  endtask

  task automatic op2(input string tag, input bit wr, input logic [1:0] sz, input bit sg,
                     input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    bit e_err, g_err;
    logic [31:0] e_rd;
    model(wr, sz, sg, a, wd, e_err, e_rd);
    req2(wr, sz, sg, a, wd, rd, g_err);
    check_eq({tag, "_err"}, 32'(g_err), 32'(e_err));
    check_eq({tag, "_rdata"}, rd, e_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, sv, a;
    logic [1:0] sz;
    bit seen;
    v2 = 0; wr2 = 0; sz2 = 0; sg2 = 0; a2 = 0; wd2 = 0;
    v0 = 0; wr0 = 0; sz0 = 0; sg0 = 0; a0 = 0; wd0 = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", 32'(rdy2), 1);
    check_eq("rst_rspvalid", 32'(rv2), 0);
    check_eq("rst_rdata", rd2, 0);
    check_eq("rst_error", 32'(re2), 0);
    check_eq("rst_ready0", 32'(rdy0), 1);

    for (int i = 0; i < 16; i++) op2("init", 1, 2'b10, 0, 32'(i * 4), $urandom, rd);

    op2("sw", 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, rd);
    check_eq("sw_zero", rd, 0);
    op2("lw", 0, 2'b10, 0, 32'h10, 0, rd);
    check_eq("lw_val", rd, 32'hDEAD_BEEF);

    op2("sw2", 1, 2'b10, 0, 32'h10, 32'h1122_3344, rd);
    op2("sb", 1, 2'b00, 0, 32'h13, 32'h0000_0080, rd);
    op2("lb", 0, 2'b00, 1, 32'h13, 0, rd);
    check_eq("lb_val", rd, 32'hFFFF_FF80);
    op2("lbu", 0, 2'b00, 0, 32'h13, 0, rd);
    check_eq("lbu_val", rd, 32'h0000_0080);
    op2("lh", 0, 2'b01, 1, 32'h12, 0, rd);
    check_eq("lh_val", rd, 32'hFFFF_8022);
    op2("lw2", 0, 2'b10, 0, 32'h10, 0, rd);
    check_eq("lw2_val", rd, 32'h8022_3344);

    op2("mis_w", 0, 2'b10, 0, 32'h06, 0, rd);
    check_eq("mis_w_err", 32'(re2), 1);
    op2("mis_h", 0, 2'b01, 0, 32'h01, 0, rd);
    check_eq("mis_h_err", 32'(re2), 1);
    op2("bad_sz", 0, 2'b11, 0, 32'h00, 0, rd);
    check_eq("bad_sz_err", 32'(re2), 1);
    op2("oor", 1, 2'b10, 0, 32'(DEPTH * 4), 32'hFFFF_FFFF, rd);
    check_eq("oor_err", 32'(re2), 1);
    op2("w0", 0, 2'b10, 0, 32'h0, 0, rd);

    op2("clr20", 1, 2'b10, 0, 32'h20, 0, rd);
    @(negedge clk);
    wr2 = 1; sz2 = 2'b10; sg2 = 0; a2 = 32'h20; wd2 = 32'hCAFE_F00D; v2 = 1;
    @(posedge clk);
    @(negedge clk);
    v2 = 0;
    rst_n = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rv2) seen = 1;
    end
    rst_n = 1'b1;
    check_eq("abort_no_rsp", 32'(seen), 0);
    check_eq("abort_rdata_rst", rd2, 0);
    op2("ld20", 0, 2'b10, 0, 32'h20, 0, rd);
    check_eq("ld20_val", rd, 0);

    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = 32'(DEPTH * 4) + $urandom_range(0, 255);
      else                           a = $urandom_range(0, 63);
      op2("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd);
    end

    sv = $urandom;
    @(negedge clk);
    check_eq("l0_ready", 32'(rdy0), 1);
    wr0 = 1; sz0 = 2'b10; sg0 = 0; a0 = 32'h40; wd0 = sv; v0 = 1;
    @(posedge clk);
    @(negedge clk);
    check_eq("l0_rsp1", 32'(rv0), 1);
    check_eq("l0_busy", 32'(rdy0), 0);
    wr0 = 0;
    @(negedge clk);
    check_eq("l0_resp_ignored", 32'(rv0), 0);
    check_eq("l0_ready2", 32'(rdy0), 1);
    check_eq("l0_st_err", 32'(re0), 0);
    @(negedge clk);
    check_eq("l0_rsp2", 32'(rv0), 1);
    check_eq("l0_raw", rd0, sv);
    v0 = 0;
    @(negedge clk);
    check_eq("l0_pulse", 32'(rv0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder: the memory end of the load/store interface driven by the datapath's memory stage. Accepts one read or write request at a time over a valid/ready handshake. Holds the request for a fixed number of wait cycles, then performs the word-, halfword- or byte-sized little-endian access and returns a single-cycle response with load data and an error flag. It replaces the combinational data memory when the datapath moves to a stalling memory stage.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words of storage (power of two).
- LATENCY, 2: wait cycles between request acceptance and the commit edge (0 legal).
- Clk  input  1  single clock, rising edge.
- Reset  input  1  asynchronous, active-low reset (Reset=0 resets).
- ReqValid  input  1  initiator presents a request.
- ReqReady  output  1  responder can accept; request accepted on an edge with ReqValid&&ReqReady.
- ReqWrite  input  1  1=store, 0=load.
- ReqSize  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- ReqSigned  input  1  loads only: 1 sign-extends byte/half, 0 zero-extends.
- ReqAddr  input  32  byte address.
- ReqWData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- RspValid  output  1  one-cycle response pulse.
- RspRData  output  32  load result, extended; 0 for stores and errored accesses.
- RspError  output  1  valid with RspValid: access was misaligned, out of range or illegal size.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: ReqReady=1. On acceptance, register Write/Size/Signed/Addr/WData. Go to WAIT if LATENCY>0, otherwise go straight to commit (see below).
- WAIT: ReqReady=0; a down-counter loaded with LATENCY-1 decrements each cycle. The edge on which the counter is 0 is the commit edge; go to RESP.
- Commit edge:
  - Error check, first match wins: size 11; half with Addr[0]≠0; word with Addr[1:0]≠00; Addr[31:2] ≥ DEPTH_WORDS.
  - Error: no memory update; RspRData←0; RspError←1.
  - Store: update only the addressed lanes of word Addr[31:2]. Byte lane = Addr[1:0]; half lanes = Addr[1]*2 and Addr[1]*2+1. RspRData←0.
  - Load: extract the lane(s) and extend per ReqSigned into RspRData. Word loads ignore ReqSigned.
- RESP: RspValid=1 for exactly one cycle, ReqReady=0, then return to IDLE.
- RspRData/RspError hold their values after RESP until the next commit.
- ReqValid asserted outside IDLE is ignored. The initiator holds its request until ReqReady; the responder does not require it to be held after acceptance.
- Storage contents are not reset and are undefined until written.

## Timing
- Reset (async assert): state→IDLE, counter→0, ReqReady=1 after deassert, RspValid=0, RspRData=0, RspError=0.
  - Reset during WAIT aborts the request; no write occurs.
  - Reset coincident with a commit edge also suppresses the write.
- Acceptance on edge k → commit on edge k+LATENCY → RspValid high in the cycle after edge k+LATENCY → ReqReady high again one cycle later.
- Throughput: one request per LATENCY+2 cycles. With LATENCY=0 that is accept at k, response cycle k+1, next acceptance at edge k+2.
- Read-after-write to the same address returns the new data; the write has committed before the next request can be accepted.
- ReqReady is a registered function of state only, with no combinational path from ReqValid.

## Test plan
- Reset/idle: hold Reset=0 for 3 cycles, release → ReqReady=1, RspValid=0, RspRData=0, RspError=0.
- Word store/load, LATENCY=2:
  - Store 0xDEADBEEF to 0x10 accepted at edge k → RspValid in cycle k+3, RspError=0, RspRData=0, ReqReady back at k+4.
  - Load word 0x10 → RspRData=0xDEADBEEF.
- Sub-word access:
  - Store byte 0x80 at 0x13 onto word 0x11223344, then load signed byte 0x13 → 0xFFFFFF80; load unsigned byte → 0x00000080.
  - Load signed half 0x12 → 0xFFFF8022; load word 0x10 → 0x80223344.
- Errors:
  - Word load at 0x06, half at 0x01, size 11 → each RspError=1, RspRData=0.
  - Word store to byte address DEPTH_WORDS*4 → RspError=1, and a reload of word 0 is unchanged.
- Reset mid-WAIT: accept store of 0xCAFEF00D to 0x20 (word previously 0x0), assert Reset during WAIT → no RspValid; after release, load 0x20 returns 0x00000000.
- LATENCY=0 back-to-back: hold ReqValid high with store then load to 0x40 → acceptances two cycles apart, second RspRData equals the stored value; ReqValid during RESP is not accepted.
